// File: rtl/arbiter_12_rr.sv
// ---------------------------------------------------------------------------
// arbiter_12_rr
//
// Round-robin arbiter that shares one resource among 12 requesters.
// The grant is presented both as a one-hot vector and as a 4-bit code
// (0 = none, k = 1..12 means requester k-1). The one-hot vector is always
// the 4-to-12 decode of the code, so downstream logic may use either form.
//
// A grant ends when the holder asserts done or drops its request. At least
// one idle cycle separates consecutive grants. The rotation pointer moves
// to the requester after the one just released.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   - a grant lasts at most MAX_HOLD cycles. A forced release
//               pulses timeout for one cycle.
//   undefined - there is no hold limit and timeout is tied to 0.
//
// Parameters:
//   N_REQ     number of requesters (fixed at 12)
//   MAX_HOLD  maximum grant length when the timeout feature is built (1..255)
//   HOLD_W    width of the saturating hold counter (must hold MAX_HOLD)
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   req       level-sensitive request vector, bit i = requester i
//   done      current holder releases the resource this cycle
//   gnt       registered one-hot grant, or zero
//   gnt_code  registered grant code, 0 = none, i+1 = requester i
//   busy      registered, high while a grant is held
//   timeout   one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module arbiter_12_rr #(
    parameter int N_REQ    = 12,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [3:0]       gnt_code,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    // Round-robin search starting at ptr, wrapping at N_REQ.
    logic       pick_valid;
    logic [3:0] pick_idx;
    logic [4:0] scan_sum;
    logic [3:0] scan_idx;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan_sum = {1'b0, ptr} + 5'(off);
            scan_idx = (scan_sum >= 5'(N_REQ)) ? 4'(scan_sum - 5'(N_REQ)) : scan_sum[3:0];
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // The holder's index is gnt_code-1. It is only meaningful in GRANT,
    // where gnt_code is 1..12.
    logic [3:0] hold_idx;
    logic       holder_req;
    logic       forced;
    logic       release_now;

    assign hold_idx    = gnt_code - 4'd1;
    assign holder_req  = req[hold_idx];
    assign release_now = (state == GRANT) && (done || !holder_req || forced);

`ifdef ARB_TIMEOUT_EN
    // Forced release happens only when done is low. If done coincides with
    // the limit, the release counts as a normal one.
    assign forced = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD)) && !done;

    logic timeout_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forced;
        end
    end

    assign timeout = timeout_q;
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;

    // MAX_HOLD has no function without the hold limit.
    logic [HOLD_W-1:0] unused_max_hold;
    assign unused_max_hold = HOLD_W'(MAX_HOLD);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_code <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // done is ignored here. Only a request starts a grant.
                    if (pick_valid) begin
                        state    <= GRANT;
                        gnt      <= N_REQ'(1) << pick_idx;
                        gnt_code <= pick_idx + 4'd1;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_code <= '0;
                        busy     <= 1'b0;
                        // The next pointer is (w+1) mod 12, which equals
                        // gnt_code unless w was the last requester.
                        ptr      <= (gnt_code == 4'(N_REQ)) ? 4'd0 : gnt_code;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
